system_fifo_seq_ctrl: RTL

SYSTEM_FIFO_SEQ_CTRL -- requirements
Module: system_fifo_seq_ctrl

---
 rtl/system_fifo_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/system_fifo_seq_ctrl.sv
// Write/read burst sequencer for a 64-bit FIFO: issues N_TURB-slot bursts,
// tracks FIFO occupancy, gates requests at full/empty and flags over/underflow.
`ifndef N_WindTurbine
`define N_WindTurbine 4
`endif

module system_fifo_seq_ctrl #(
  parameter int N_TURB = `N_WindTurbine,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_user,
  input  logic       wr_start,
  input  logic       rd_start,
  output logic       fifo_wrreq,
  output logic       fifo_rdreq,
  output logic       fifo_sclr,
  output logic       rd_valid,
  output logic [3:0] rd_idx,
  output logic [3:0] wr_idx,
  output logic       wr_busy,
  output logic       rd_busy,
  output logic       burst_done,
  output logic [4:0] occupancy,
  output logic       err_ovf,
  output logic       err_udf
);

  typedef enum logic {W_IDLE, W_RUN} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_FLUSH} rd_state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_TURB - 1);
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  wr_state_t  r_wr_state, w_wr_state_nxt;
  rd_state_t  r_rd_state, w_rd_state_nxt;
  logic [3:0] r_wr_idx, w_wr_idx_nxt;
  logic [3:0] r_rd_idx, w_rd_idx_nxt;
  logic [3:0] r_rd_idx_dly;
  logic [4:0] r_occ, w_occ_nxt;
  logic       r_ovf, w_ovf_nxt;
  logic       r_udf, w_udf_nxt;
  logic       r_sclr;
  logic       r_rd_valid;
  logic       w_wr_run, w_rd_run;
  logic       w_full, w_empty;
  logic       w_wrreq, w_rdreq;

  assign w_wr_run = (r_wr_state == W_RUN);
  assign w_rd_run = (r_rd_state == R_RUN);
  assign w_full   = !(r_occ < FULL_CNT);
  assign w_empty  = (r_occ == 5'd0);

  // Gating uses only the registered count, so a same-cycle read never frees a write slot.
  assign w_wrreq  = w_wr_run && !w_full  && !rst_user;
  assign w_rdreq  = w_rd_run && !w_empty && !rst_user;

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_idx_nxt   = r_wr_idx;
    if (rst_user) begin
      w_wr_state_nxt = W_IDLE;
      w_wr_idx_nxt   = 4'd0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (wr_start) begin
            w_wr_state_nxt = W_RUN;
            w_wr_idx_nxt   = 4'd0;
          end
        end
        W_RUN: begin
          if (r_wr_idx == LAST_IDX) begin
            w_wr_state_nxt = W_IDLE;
            w_wr_idx_nxt   = 4'd0;
          end else begin
            w_wr_idx_nxt = r_wr_idx + 4'd1;
          end
        end
        default: begin
          w_wr_state_nxt = W_IDLE;
          w_wr_idx_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_idx_nxt   = r_rd_idx;
    if (rst_user) begin
      w_rd_state_nxt = R_IDLE;
      w_rd_idx_nxt   = 4'd0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (rd_start) begin
            w_rd_state_nxt = R_RUN;
            w_rd_idx_nxt   = 4'd0;
          end
        end
        R_RUN: begin
          if (r_rd_idx == LAST_IDX) begin
            w_rd_state_nxt = R_FLUSH;
            w_rd_idx_nxt   = 4'd0;
          end else begin
            w_rd_idx_nxt = r_rd_idx + 4'd1;
          end
        end
        R_FLUSH: begin
          w_rd_state_nxt = R_IDLE;
        end
        default: begin
          w_rd_state_nxt = R_IDLE;
          w_rd_idx_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    w_ovf_nxt = r_ovf;
    w_udf_nxt = r_udf;
    if (rst_user) begin
      w_occ_nxt = 5'd0;
      w_ovf_nxt = 1'b0;
      w_udf_nxt = 1'b0;
    end else begin
      if (w_wrreq && !w_rdreq) begin
        w_occ_nxt = r_occ + 5'd1;
      end else if (!w_wrreq && w_rdreq) begin
        w_occ_nxt = r_occ - 5'd1;
      end
      if (w_wr_run && w_full) begin
        w_ovf_nxt = 1'b1;
      end
      if (w_rd_run && w_empty) begin
        w_udf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state   <= W_IDLE;
      r_rd_state   <= R_IDLE;
      r_wr_idx     <= 4'd0;
      r_rd_idx     <= 4'd0;
      r_rd_idx_dly <= 4'd0;
      r_occ        <= 5'd0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_sclr       <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_wr_state   <= w_wr_state_nxt;
      r_rd_state   <= w_rd_state_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_rd_idx_dly <= r_rd_idx;
      r_occ        <= w_occ_nxt;
      r_ovf        <= w_ovf_nxt;
      r_udf        <= w_udf_nxt;
      r_sclr       <= rst_user;
      // Not cleared by rst_user: a word already requested still arrives.
      r_rd_valid   <= w_rdreq;
    end
  end

  assign fifo_wrreq = w_wrreq;
  assign fifo_rdreq = w_rdreq;
  assign fifo_sclr  = r_sclr;
  assign rd_valid   = r_rd_valid;
  assign rd_idx     = r_rd_idx_dly;
  assign wr_idx     = r_wr_idx;
  assign wr_busy    = w_wr_run;
  assign rd_busy    = (r_rd_state != R_IDLE);
  assign burst_done = (r_rd_state == R_FLUSH) && !rst_user;
  assign occupancy  = r_occ;
  assign err_ovf    = r_ovf;
  assign err_udf    = r_udf;

endmodule
